// File: rtl/dbus_ctrl.sv
// Data-bus controller: turns single pipeline load/store requests into one
// MREQ/ACKD_n bus cycle with lane placement, load extension and a wait timeout.
module dbus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [CW-1:0] cnt_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        bad_req;
    logic        ack;
    logic        tmo;
    logic        ddt_en;

    function automatic logic [31:0] lane_place(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        case (sz)
            2'b00:   r = d;
            2'b01:   r = {16'h0000, d[15:0]};
            2'b10:   r = {24'h000000, d[7:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic uns,
                                                input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        case (sz)
            2'b00:   r = d;
            2'b01:   r = {{16{d[15] & ~uns}}, d[15:0]};
            2'b10:   r = {{24{d[7] & ~uns}}, d[7:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        accept    = req_valid && req_ready;
        bad_req   = (req_size == 2'b11) ||
                    (req_size == 2'b00 && req_addr[1:0] != 2'b00) ||
                    (req_size == 2'b01 && req_addr[0]);
        ack       = !ACKD_n;
        // an ack on the final wait cycle takes priority over the timeout
        tmo       = !ack && (cnt_q == LAST);
        ddt_en    = MREQ && WRITE;
    end

    assign DDT = ddt_en ? wdata_q : 'z;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = bad_req ? RESP : BUS;
            end
            BUS: begin
                if (ack || tmo) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= 2'b00;
            DAD        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    if (accept) begin
                        if (bad_req) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            MREQ    <= 1'b1;
                            DAD     <= req_addr;
                            WRITE   <= req_write;
                            SIZE    <= req_size;
                            uns_q   <= req_unsigned;
                            wdata_q <= lane_place(req_size, req_wdata);
                            cnt_q   <= '0;
                        end
                    end
                end
                BUS: begin
                    if (ack) begin
                        MREQ       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= WRITE ? '0 : load_extend(SIZE, uns_q, DDT);
                    end else if (tmo) begin
                        MREQ       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    MREQ       <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Scoreboard bench for dbus_ctrl with a behavioural bus responder (TIMEOUT=4).
module tb_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] DAD;
    wire  [31:0] DDT;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n = 1'b1;

    logic        tb_drv = 1'b0;
    logic [31:0] tb_data = '0;
    assign DDT = tb_drv ? tb_data : 'z;

    dbus_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .DAD(DAD), .DDT(DDT),
        .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          mreqs;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          mreq_cnt = 0;
    int          bus_cyc = 0;
    int          ack_cycle = 1;
    logic [31:0] bus_rdata = '0;
    logic [31:0] exp_addr = '0;
    logic [1:0]  exp_size = 2'b00;
    logic        exp_write = 1'b0;
    logic [31:0] exp_ddt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // bus slave: acks on the ack_cycle-th MREQ cycle (0 = never)
    always @(posedge clk) begin
        #1;
        if (MREQ) begin
            bus_cyc++;
            if (bus_cyc == ack_cycle) begin
                ACKD_n = 1'b0;
                tb_drv = !WRITE;
                tb_data = bus_rdata;
            end else begin
                ACKD_n = 1'b1;
                tb_drv = 1'b0;
            end
        end else begin
            bus_cyc = 0;
            ACKD_n = 1'b1;
            tb_drv = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            mreq_cnt = 0;
        end else begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (MREQ) begin
                mreq_cnt++;
                check("bus_addr", DAD, exp_addr);
                check("bus_size", {30'd0, SIZE}, {30'd0, exp_size});
                check("bus_write", {31'd0, WRITE}, {31'd0, exp_write});
                if (exp_write) check("store_ddt", DDT, exp_ddt);
            end else begin
                check("ddt_hiz", {31'd0, dut.ddt_en}, 32'd0);
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("resp_latency", cyc - acc_cyc, e.lat);
                    check("mreq_cycles", mreq_cnt, e.mreqs);
                    check("ready_in_resp", {31'd0, req_ready}, 32'd0);
                end
                mreq_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int ackc, input logic [31:0] rd);
        exp_t e;
        logic bad;
        logic acked;
        bad   = (sz == 2'b11) || (sz == 2'b00 && addr[1:0] != 2'b00) ||
                (sz == 2'b01 && addr[0]);
        acked = (ackc >= 1) && (ackc <= 4);
        e.mreqs = bad ? 0 : (acked ? ackc : 4);
        e.err   = bad || !acked;
        e.lat   = bad ? 1 : e.mreqs + 1;
        e.rdata = '0;
        if (!e.err && !w) begin
            case (sz)
                2'b00:   e.rdata = rd;
                2'b01:   e.rdata = uns ? {16'h0, rd[15:0]} : {{16{rd[15]}}, rd[15:0]};
                default: e.rdata = uns ? {24'h0, rd[7:0]} : {{24{rd[7]}}, rd[7:0]};
            endcase
        end
        case (sz)
            2'b00:   exp_ddt = wdata;
            2'b01:   exp_ddt = {16'h0, wdata[15:0]};
            default: exp_ddt = {24'h0, wdata[7:0]};
        endcase
        exp_addr  = addr;
        exp_size  = sz;
        exp_write = w;
        ack_cycle = ackc;
        bus_rdata = rd;
        sb.push_back(e);
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wdata;
        @(posedge clk) #1;
        // keep presenting a different request while busy; it must be ignored
        req_addr = ~addr;
        req_size = 2'b11;
        @(posedge clk) #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk) #1;
        if (sb.size() != 0) begin
            check("resp_wait_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 1 expected 0");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_mreq", {31'd0, MREQ}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_dad", DAD, 32'd0);
        check("rst_size_write", {29'd0, SIZE, WRITE}, 32'd0);
        check("rst_ddt_hiz", {31'd0, dut.ddt_en}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(posedge clk) #1;

        do_req(1'b0, 2'b00, 1'b0, 32'h0800_0004, 32'h0, 1, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h0000_0080);
        do_req(1'b0, 2'b10, 1'b1, 32'h0000_0013, 32'h0, 1, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 1, 32'h0000_F234);
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 2, 32'h0000_F234);
        do_req(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h1234_5641, 1, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'hCAFE_8765, 3, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0200, 32'hA5A5_0F0F, 1, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 1, 32'h1111_1111);
        do_req(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h1111_1111);
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h55, 1, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h7777_7777);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0044, 32'h0, 4, 32'h8000_0001);
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0045, 32'h99, 5, 32'h0);
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = $urandom & ((sz == 2'b00) ? 32'hFFFF_FFFC : (sz == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(1, 4), $urandom);
        end

        // reset on the 2nd BUS cycle of a store, with an ack landing on that same edge
        exp_addr  = 32'h0000_0100;
        exp_size  = 2'b00;
        exp_write = 1'b1;
        exp_ddt   = 32'hAABB_CCDD;
        ack_cycle = 2;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b00;
        req_addr = 32'h0000_0100;
        req_wdata = 32'hAABB_CCDD;
        @(posedge clk) #1;
        req_valid = 1'b0;
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        check("abort_mreq", {31'd0, MREQ}, 32'd0);
        check("abort_ddt_hiz", {31'd0, dut.ddt_en}, 32'd0);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_ready_in_rst", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", {31'd0, req_ready}, 32'd1);
        @(posedge clk) #1;
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        check("abort_idle_mreq", {31'd0, MREQ}, 32'd0);

        do_req(1'b0, 2'b00, 1'b0, 32'h0800_0004, 32'h0, 1, 32'h0BAD_F00D);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
